// File: rtl/mem_bus_ctrl_pkg.sv
// Shared types for the core-side memory bus controller: access sizes,
// controller states and default widths.
package mem_bus_ctrl_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_BE_W   = MEM_DATA_W / 8;

  // Access size requested by the core; encoding 3 is unused and treated as a word.
  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_t;

  // Controller phase: waiting for a request, bus cycle in flight, completion.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// Avalon-MM master bundle between the controller and the memory slave.
interface mem_bus_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0]   avm_address_o;
  logic                avm_read_o;
  logic                avm_write_o;
  logic [DATA_W-1:0]   avm_writedata_o;
  logic [DATA_W/8-1:0] avm_byteenable_o;
  logic                avm_waitrequest_i;
  logic [DATA_W-1:0]   avm_readdata_i;

  modport master (
    output avm_address_o,
    output avm_read_o,
    output avm_write_o,
    output avm_writedata_o,
    output avm_byteenable_o,
    input  avm_waitrequest_i,
    input  avm_readdata_i
  );

  modport slave (
    input  avm_address_o,
    input  avm_read_o,
    input  avm_write_o,
    input  avm_writedata_o,
    input  avm_byteenable_o,
    output avm_waitrequest_i,
    output avm_readdata_i
  );

endinterface

// File: rtl/mem_bus_ctrl_lane_fmt.sv
// Combinational byte-lane steering: store byteenable and data replication,
// misalignment detection of the live request, and load lane extraction with
// sign/zero extension of the captured read word. Little-endian lanes.
module mem_lane_fmt
  import mem_bus_ctrl_pkg::*;
(
  // store / request side (live core request)
  input  mem_size_t   st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata_rep,
  output logic        st_misaligned,
  // load side (attributes registered at request time)
  input  mem_size_t   ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_signed,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  lane [4];
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Split the read word into its four byte lanes.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane[gi] = ld_rdata[8*gi +: 8];
  end

  // Store lanes: enable only the addressed bytes and replicate data across the word.
  always_comb begin
    st_be         = 4'b1111;
    st_wdata_rep  = st_wdata;
    st_misaligned = 1'b0;
    case (st_size)
      MEM_BYTE: begin
        st_be        = 4'b0001 << st_off;
        st_wdata_rep = {4{st_wdata[7:0]}};
      end
      MEM_HALF: begin
        st_be         = st_off[1] ? 4'b1100 : 4'b0011;
        st_wdata_rep  = {2{st_wdata[15:0]}};
        st_misaligned = st_off[0];
      end
      default: begin
        st_misaligned = (st_off != 2'b00);
      end
    endcase
  end

  // Load lanes: pick the addressed byte/half and extend it to a full word.
  always_comb begin
    ld_byte = lane[ld_off];
    ld_half = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    case (ld_size)
      MEM_BYTE: ld_data = {{24{ld_signed & ld_byte[7]}}, ld_byte};
      MEM_HALF: ld_data = {{16{ld_signed & ld_half[15]}}, ld_half};
      default:  ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Core-side memory bus controller: turns one core request into one Avalon-MM
// access, stalls the core until it completes and formats load data.
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              reset_ni,
  input  logic              req_valid_i,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  mem_size_t         req_size_i,
  input  logic              req_signed_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rdata_valid_o,
  output logic              misaligned_o,
  mem_bus_ctrl_if.master    avm
);

  mem_state_t        state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              read_reg;
  logic              write_reg;
  logic [3:0]        be_reg;
  logic [31:0]       wdata_reg;
  mem_size_t         ld_size_reg;
  logic [1:0]        ld_off_reg;
  logic              ld_signed_reg;
  logic [31:0]       rdata_reg;
  logic              rdata_valid_reg;

  logic [3:0]        fmt_be;
  logic [31:0]       fmt_wdata;
  logic              fmt_misaligned;
  logic [31:0]       fmt_ld_data;
  logic              req_accept;

  mem_lane_fmt u_lane_fmt (
    .st_size       (req_size_i),
    .st_off        (req_addr_i[1:0]),
    .st_wdata      (req_wdata_i),
    .st_be         (fmt_be),
    .st_wdata_rep  (fmt_wdata),
    .st_misaligned (fmt_misaligned),
    .ld_size       (ld_size_reg),
    .ld_off        (ld_off_reg),
    .ld_signed     (ld_signed_reg),
    .ld_rdata      (avm.avm_readdata_i),
    .ld_data       (fmt_ld_data)
  );

  // A request is taken only in IDLE and only if it is aligned.
  assign req_accept = (state_reg == IDLE) && req_valid_i && !fmt_misaligned;

  // Access sequencer: latch the request, hold the bus cycle through waitrequest,
  // then signal completion for one cycle. Bus strobes drop at once on reset.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      state_reg       <= IDLE;
      addr_reg        <= '0;
      read_reg        <= 1'b0;
      write_reg       <= 1'b0;
      be_reg          <= 4'b0000;
      wdata_reg       <= '0;
      ld_size_reg     <= MEM_BYTE;
      ld_off_reg      <= 2'b00;
      ld_signed_reg   <= 1'b0;
      rdata_reg       <= '0;
      rdata_valid_reg <= 1'b0;
    end else begin
      rdata_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_accept) begin
            addr_reg      <= {req_addr_i[ADDR_W-1:2], 2'b00};
            read_reg      <= !req_write_i;
            write_reg     <= req_write_i;
            be_reg        <= fmt_be;
            wdata_reg     <= fmt_wdata;
            ld_size_reg   <= req_size_i;
            ld_off_reg    <= req_addr_i[1:0];
            ld_signed_reg <= req_signed_i;
            state_reg     <= BUS;
          end
        end
        BUS: begin
          if (!avm.avm_waitrequest_i) begin
            if (read_reg) begin
              rdata_reg <= fmt_ld_data;
            end
            rdata_valid_reg <= read_reg;
            read_reg        <= 1'b0;
            write_reg       <= 1'b0;
            state_reg       <= RESP;
          end
        end
        RESP: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign stall_o       = req_accept || (state_reg == BUS);
  assign misaligned_o  = (state_reg == IDLE) && req_valid_i && fmt_misaligned;
  assign rdata_o       = rdata_reg;
  assign rdata_valid_o = rdata_valid_reg;

  assign avm.avm_address_o    = addr_reg;
  assign avm.avm_read_o       = read_reg;
  assign avm.avm_write_o      = write_reg;
  assign avm.avm_writedata_o  = wdata_reg;
  assign avm.avm_byteenable_o = be_reg;

endmodule
